cascade_counter: RTL and testbench
==================================

// Module: cascade_counter
// PURPOSE
//  Parametrised successor to the generic timing counter. Adds up/down counting,
//    runtime terminal value, parallel load, wrap or saturate mode, a built-in prescaler,
//    and cascade carry in/out.
//  Targets VGA h/v timing chains (h cout drives v cin), ball/paddle speed dividers,
//    and score/timeout counters in the Pong top level.
// PARAMETERS
//  WIDTH     10  counter width in bits; Q, limit and load_val use this width
//  PRESCALE  1   count requests per step (>=1); 1 = no prescaling, no prescaler logic
// PORTS
//  clk       in   1      system clock, rising edge
//  reset_n   in   1      asynchronous, active-low reset
//  ctrl      in   2      00 hold, 01 count, 10 load, 11 clear
//  dir       in   1      0 up, 1 down
//  mode      in   1      0 wrap, 1 saturate
//  limit     in   WIDTH  terminal value (inclusive); may change any cycle
//  load_val  in   WIDTH  value taken on ctrl=10
//  cin       in   1      cascade enable; count requests are qualified by cin
//  Q         out  WIDTH  current count
//  roll      out  1      combinational at_term level
//  cout      out  1      combinational carry: step & at_term
//  tc        out  1      registered one-cycle pulse, the cycle after a cout
// BEHAVIOUR
//  Reset (reset_n=0, async): Q=0, tc=0, prescaler=0; cout and roll follow from Q.
//  Request and step:
//    req  = (ctrl==01) & cin
//    tick = (pre==PRESCALE-1); tick is constant 1 when PRESCALE=1
//    step = req & tick
//  Prescaler:
//    pre advances only on req; wraps to 0 on tick.
//    ctrl=10 or ctrl=11 forces pre=0.
//    cin=0 or ctrl=00 freezes pre.
//  at_term:
//    up:   Q >= limit; the >= covers limit lowered below Q
//    down: Q == 0
//  Priority per edge: clear(11) > load(10) > step > hold.
//    Clear: Q <= 0.
//    Load:  Q <= (load_val > limit) ? limit : load_val (clamped).
//  Step, up:
//    !at_term          -> Q+1
//    at_term, wrap     -> 0
//    at_term, saturate -> limit (also pulls Q>limit back to limit)
//  Step, down:
//    Q != 0            -> Q-1
//    Q == 0, wrap      -> limit
//    Q == 0, saturate  -> stays 0
//  cout fires on every step taken while at_term, in both modes; saturated counters
//    therefore emit cout on each step.
//  tc <= cout every cycle (latency 1). Clear and load do not force tc.
//  dir or mode changes take effect on the next edge; no state is retained.
//  limit=0: Q is pinned at 0; at_term is always 1; every step gives cout.
//  Arithmetic is WIDTH bits. No overflow can occur, since limit <= 2^WIDTH-1 bounds Q.
//  Reset asserted mid-count: Q drops to 0 immediately, with no clock required.
//    Counting restarts on the first edge after reset_n rises.
// STRUCTURE
//  Shared header counter_defs.vh:
//    CTRL_HOLD/COUNT/LOAD/CLEAR encodings
//    DIR_UP/DIR_DOWN
//    MODE_WRAP/MODE_SAT
//  Sub-module counter_prescaler (PRESCALE param; ports clk, reset_n, req, clr, tick).
//    Generate-bypassed when PRESCALE=1.
//  Top module holds: next-state mux, at_term compare, load clamp, tc flop.
// TESTING
//  1. W=10, limit=799, up, wrap, cin=1, ctrl=01 for 800 cycles:
//     Q runs 0..799, roll=1 only at 799; cout=1 in that cycle; Q->0; tc=1 the next cycle.
//  2. limit=5, up, saturate, 8 steps:
//     Q=0,1..5,5,5; cout=1 on steps 6-8; Q never exceeds 5.
//  3. limit=9, load_val=3, then down/wrap, 5 steps:
//     Q=3,2,1,0,9; cout at Q=0 step; tc one cycle later.
//  4. PRESCALE=4, ctrl=01:
//     Q increments every 4th cycle. Dropping cin for 3 cycles mid-period delays the step by 3.
//     ctrl=11 resets Q=0 and pre=0.
//  5. Priority and limit:
//     ctrl=10 with load_val=900, limit=799 -> Q=799.
//     At Q=500, set limit=100 (up/wrap) -> next step Q=0, cout=1.
//     ctrl=11 with cin=1 -> Q=0.
//  6. Drive reset_n low between edges at Q=37, tc=1:
//     Q=0 and tc=0 before the next edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared encodings for the cascade counter family: control opcodes, direction and end-of-range mode.
package cascade_counter_pkg;

    typedef enum logic [1:0] {
        CTRL_HOLD  = 2'b00,
        CTRL_COUNT = 2'b01,
        CTRL_LOAD  = 2'b10,
        CTRL_CLEAR = 2'b11
    } ctrl_e;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/cascade_counter_prescaler.sv
// Divides qualified count requests by PRESCALE; tick is high on the request that completes a period.
module cascade_counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;

    assign tick = (pre_reg == PRE_W'(PRESCALE - 1));

    // Without a request the phase is frozen, so a paused cascade resumes mid-period.
    always_comb begin
        pre_next = pre_reg;
        if (clr) begin
            pre_next = '0;
        end else if (req) begin
            pre_next = tick ? '0 : pre_reg + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

endmodule

// File: rtl/cascade_counter.sv
// Up/down counter with runtime terminal value, clamped load, wrap/saturate ends, prescaler and cascade carry.
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       ctrl,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cin,
    output logic [WIDTH-1:0] Q,
    output logic             roll,
    output logic             cout,
    output logic             tc
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             tc_reg;
    logic             req;
    logic             tick;
    logic             step;
    logic             at_term;
    ctrl_e            op;

    assign op   = ctrl_e'(ctrl);
    assign req  = (op == CTRL_COUNT) && cin;
    assign step = req && tick;

    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign tick = 1'b1;
        end else begin : g_pre
            logic pre_clr;
            assign pre_clr = (op == CTRL_LOAD) || (op == CTRL_CLEAR);
            cascade_counter_prescaler #(
                .PRESCALE(PRESCALE)
            ) u_pre (
                .clk    (clk),
                .reset_n(reset_n),
                .req    (req),
                .clr    (pre_clr),
                .tick   (tick)
            );
        end
    endgenerate

    // >= rather than == so a limit lowered beneath the count still terminates it.
    assign at_term = (dir == DIR_UP) ? (q_reg >= limit) : (q_reg == '0);

    always_comb begin
        q_next = q_reg;
        case (op)
            CTRL_CLEAR: q_next = '0;
            CTRL_LOAD:  q_next = (load_val > limit) ? limit : load_val;
            CTRL_COUNT: begin
                if (step) begin
                    if (dir == DIR_UP) begin
                        if (!at_term)             q_next = q_reg + WIDTH'(1);
                        else if (mode == MODE_SAT) q_next = limit;
                        else                      q_next = '0;
                    end else begin
                        if (!at_term)             q_next = q_reg - WIDTH'(1);
                        else if (mode == MODE_SAT) q_next = '0;
                        else                      q_next = limit;
                    end
                end
            end
            default:    q_next = q_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg  <= '0;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= cout;
        end
    end

    assign Q    = q_reg;
    assign roll = at_term;
    assign cout = step && at_term;
    assign tc   = tc_reg;

endmodule

// File: tb/tb_cascade_counter.sv
// Checks an unprescaled and a divide-by-4 counter, driven in parallel, against an arithmetic reference model.
module tb_cascade_counter;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   ctrl = 2'b00;
    logic         dir = 1'b0;
    logic         mode = 1'b0;
    logic         cin = 1'b1;
    logic [W-1:0] limit = 10'd799;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] q1, q4;
    logic         roll1, roll4, cout1, cout4, tc1, tc4;

    int checks = 0;
    int failures = 0;

    int mq[2];
    int mpre[2];
    int mtc[2];
    int pdiv[2] = '{1, 4};

    always #5 clk = ~clk;

    cascade_counter #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .dir(dir), .mode(mode),
        .limit(limit), .load_val(load_val), .cin(cin),
        .Q(q1), .roll(roll1), .cout(cout1), .tc(tc1)
    );

    cascade_counter #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .dir(dir), .mode(mode),
        .limit(limit), .load_val(load_val), .cin(cin),
        .Q(q4), .roll(roll4), .cout(cout4), .tc(tc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_at(input int i);
        return dir ? (mq[i] == 0) : (mq[i] >= int'(limit));
    endfunction

    function automatic bit m_step(input int i);
        return (ctrl == 2'b01) && cin && (mpre[i] == pdiv[i] - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mpre[i] = 0; mtc[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit at, st;
            int lim;
            at  = m_at(i);
            st  = m_step(i);
            lim = int'(limit);
            mtc[i] = st && at;
            if (ctrl == 2'b11) begin
                mq[i] = 0; mpre[i] = 0;
            end else if (ctrl == 2'b10) begin
                mq[i] = (int'(load_val) > lim) ? lim : int'(load_val);
                mpre[i] = 0;
            end else if (ctrl == 2'b01 && cin) begin
                mpre[i] = (mpre[i] + 1) % pdiv[i];
                if (st) begin
                    if (!dir) mq[i] = !at ? mq[i] + 1 : (mode ? lim : 0);
                    else      mq[i] = !at ? mq[i] - 1 : (mode ? 0 : lim);
                end
            end
        end
    endtask

    task automatic check_comb();
        chk("roll1", 32'(roll1), 32'(m_at(0)));
        chk("cout1", 32'(cout1), 32'(m_step(0) && m_at(0)));
        chk("roll4", 32'(roll4), 32'(m_at(1)));
        chk("cout4", 32'(cout4), 32'(m_step(1) && m_at(1)));
    endtask

    task automatic check_regs();
        chk("q1", 32'(q1), 32'(mq[0]));
        chk("tc1", 32'(tc1), 32'(mtc[0]));
        chk("q4", 32'(q4), 32'(mq[1]));
        chk("tc4", 32'(tc4), 32'(mtc[1]));
    endtask

    // Inputs are set just after a falling edge; this finishes the cycle.
    task automatic cyc();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        #1 check_regs();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_q1", 32'(q1), 32'd0);
        chk("rst_tc1", 32'(tc1), 32'd0);
        chk("rst_q4", 32'(q4), 32'd0);
        chk("rst_roll1", 32'(roll1), 32'd0);
        reset_n = 1'b1;

        // Long up/wrap run across the 799 terminal
        ctrl = 2'b01; dir = 1'b0; mode = 1'b0; cin = 1'b1; limit = 10'd799;
        run(805);

        // Saturating up run with a small limit
        ctrl = 2'b11; run(1);
        limit = 10'd5; mode = 1'b1; ctrl = 2'b01;
        run(10);
        chk("sat_q1", 32'(q1), 32'd5);

        // Load then down/wrap
        limit = 10'd9; load_val = 10'd3; ctrl = 2'b10; run(1);
        chk("load_q1", 32'(q1), 32'd3);
        dir = 1'b1; mode = 1'b0; ctrl = 2'b01;
        run(6);

        // Prescaled counting with cin dropped mid-period
        dir = 1'b0; limit = 10'd799; ctrl = 2'b11; run(1);
        ctrl = 2'b01; run(6);
        cin = 1'b0; run(3);
        cin = 1'b1; run(6);
        ctrl = 2'b11; run(1);
        ctrl = 2'b01; run(5);

        // Load clamp and limit lowered beneath the count
        load_val = 10'd900; ctrl = 2'b10; run(1);
        chk("clamp_q1", 32'(q1), 32'd799);
        load_val = 10'd500; run(1);
        limit = 10'd100; ctrl = 2'b01; run(1);
        chk("lowlim_q1", 32'(q1), 32'd0);
        chk("lowlim_tc1", 32'(tc1), 32'd1);
        run(4);
        ctrl = 2'b11; cin = 1'b1; run(1);
        chk("clr_q1", 32'(q1), 32'd0);

        // Async reset between edges while Q=37 and tc=1
        limit = 10'd37; dir = 1'b1; mode = 1'b0; ctrl = 2'b01;
        #1 check_comb();
        @(posedge clk);
        model_edge();
        #1 check_regs();
        chk("pre_rst_q1", 32'(q1), 32'd37);
        chk("pre_rst_tc1", 32'(tc1), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_q1", 32'(q1), 32'd0);
        chk("async_tc1", 32'(tc1), 32'd0);
        chk("async_q4", 32'(q4), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1; dir = 1'b0;
        run(6);

        // Randomised traffic, biased toward short limits so terminals are frequent
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            ctrl = (r < 7) ? 2'b01 : (r == 7) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            cin  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 30) == 0)
                limit = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
            load_val = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
